// File: rtl/maxnet_sequencer.sv
// Maxnet winner-take-all sequencer: loads N activations from a combinational-read
// memory, iterates lateral inhibition until one/zero survivors or the limit, reports.
module maxnet_sequencer #(
  parameter int N         = 4,
  parameter int DW        = 4,
  parameter int FRAC      = 4,
  parameter int EPS_SHIFT = 3,
  parameter int MAX_ITER  = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic [$clog2(N)-1:0]          mem_addr,
  input  logic [DW-1:0]                 mem_data,
  output logic                          busy,
  output logic                          done,
  output logic                          winner_valid,
  output logic                          timeout,
  output logic [$clog2(N)-1:0]          winner_idx,
  output logic [DW+FRAC-1:0]            winner_act,
  output logic [$clog2(MAX_ITER+1)-1:0] iter_count
);

  localparam int AW   = DW + FRAC;
  localparam int IW   = $clog2(N);
  localparam int CW   = $clog2(MAX_ITER + 1);
  localparam int SW   = AW + $clog2(N);
  localparam int NZW  = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_ITER  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   load_idx_q, load_idx_d;
  logic [AW-1:0]   act_q [N];
  logic [AW-1:0]   act_d [N];
  logic [CW-1:0]   iter_q, iter_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            wvalid_q, wvalid_d;
  logic            tmo_q, tmo_d;
  logic [IW-1:0]   widx_q, widx_d;
  logic [AW-1:0]   wact_q, wact_d;

  logic [SW-1:0]   sum_s;
  logic [NZW-1:0]  nz_cnt_s;
  logic [IW-1:0]   nz_idx_s;
  logic [SW-1:0]   inh_s [N];
  logic [AW-1:0]   upd_s [N];

  // Population statistics: total activation, survivor count, last survivor index.
  always_comb begin
    sum_s    = '0;
    nz_cnt_s = '0;
    nz_idx_s = '0;
    for (int i = 0; i < N; i++) begin
      sum_s = sum_s + SW'(act_q[i]);
      if (act_q[i] != '0) begin
        nz_cnt_s = nz_cnt_s + NZW'(1);
        nz_idx_s = IW'(i);
      end else begin
        nz_cnt_s = nz_cnt_s;
      end
    end
  end

  // One inhibition step per neuron; the compare guarantees the ReLU floor never wraps.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      inh_s[i] = (sum_s - SW'(act_q[i])) >> EPS_SHIFT;
      if (inh_s[i] >= SW'(act_q[i])) begin
        upd_s[i] = '0;
      end else begin
        upd_s[i] = act_q[i] - inh_s[i][AW-1:0];
      end
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    load_idx_d = load_idx_q;
    iter_d     = iter_q;
    wvalid_d   = wvalid_q;
    tmo_d      = tmo_q;
    widx_d     = widx_q;
    wact_d     = wact_q;
    for (int i = 0; i < N; i++) begin
      act_d[i] = act_q[i];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          load_idx_d = '0;
          iter_d     = '0;
          wvalid_d   = 1'b0;
          tmo_d      = 1'b0;
          widx_d     = '0;
          wact_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        act_d[load_idx_q] = {mem_data, {FRAC{1'b0}}};
        if (load_idx_q == IW'(N - 1)) begin
          // Return the address to 0 so mem_addr idles at 0 outside LOAD.
          load_idx_d = '0;
          state_d    = S_CHECK;
        end else begin
          load_idx_d = load_idx_q + IW'(1);
        end
      end
      S_CHECK: begin
        if (nz_cnt_s == NZW'(1)) begin
          state_d  = S_DONE;
          wvalid_d = 1'b1;
          tmo_d    = 1'b0;
          widx_d   = nz_idx_s;
          wact_d   = act_q[nz_idx_s];
        end else if (nz_cnt_s == NZW'(0)) begin
          state_d  = S_DONE;
          wvalid_d = 1'b0;
          tmo_d    = 1'b0;
          widx_d   = '0;
          wact_d   = '0;
        end else if (iter_q == CW'(MAX_ITER)) begin
          state_d  = S_DONE;
          wvalid_d = 1'b0;
          tmo_d    = 1'b1;
          widx_d   = '0;
          wact_d   = '0;
        end else begin
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        for (int i = 0; i < N; i++) begin
          act_d[i] = upd_s[i];
        end
        iter_d  = iter_q + CW'(1);
        state_d = S_CHECK;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and result registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      load_idx_q <= '0;
      iter_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wvalid_q   <= 1'b0;
      tmo_q      <= 1'b0;
      widx_q     <= '0;
      wact_q     <= '0;
      for (int i = 0; i < N; i++) begin
        act_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      load_idx_q <= load_idx_d;
      iter_q     <= iter_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wvalid_q   <= wvalid_d;
      tmo_q      <= tmo_d;
      widx_q     <= widx_d;
      wact_q     <= wact_d;
      for (int i = 0; i < N; i++) begin
        act_q[i] <= act_d[i];
      end
    end
  end

  assign mem_addr     = load_idx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign winner_valid = wvalid_q;
  assign timeout      = tmo_q;
  assign winner_idx   = widx_q;
  assign winner_act   = wact_q;
  assign iter_count   = iter_q;

endmodule

// File: tb/tb_maxnet_sequencer.sv
// Scoreboard bench for maxnet_sequencer: a plain-arithmetic Maxnet model predicts each
// accepted run; a negedge monitor pops and compares whenever done pulses.
module tb_maxnet_sequencer;

  localparam int N = 4, DW = 4, FRAC = 4, EPS_SHIFT = 3, MAX_ITER = 15;
  localparam int AW = DW + FRAC, IW = 2, CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [IW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          busy, done, winner_valid, timeout;
  logic [IW-1:0] winner_idx;
  logic [AW-1:0] winner_act;
  logic [CW-1:0] iter_count;

  logic [DW-1:0] mem [N];
  assign mem_data = mem[mem_addr];

  maxnet_sequencer #(.N(N), .DW(DW), .FRAC(FRAC), .EPS_SHIFT(EPS_SHIFT), .MAX_ITER(MAX_ITER)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .done(done), .winner_valid(winner_valid), .timeout(timeout),
    .winner_idx(winner_idx), .winner_act(winner_act), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int valid; int tmo; int idx; int act; int iters; int done_cyc;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Maxnet from first principles on integer activations.
  function automatic exp_t ref_model();
    int a[N];
    int s, nz, w, inh;
    exp_t e;
    e = '{default: 0};
    w = 0;
    for (int i = 0; i < N; i++) a[i] = int'(mem[i]) * (1 << FRAC);
    while (1) begin
      nz = 0;
      for (int i = 0; i < N; i++) if (a[i] != 0) begin nz++; w = i; end
      if (nz == 1) begin e.valid = 1; e.idx = w; e.act = a[w]; break; end
      if (nz == 0) break;
      if (e.iters == MAX_ITER) begin e.tmo = 1; break; end
      s = 0;
      for (int i = 0; i < N; i++) s += a[i];
      for (int i = 0; i < N; i++) begin
        inh = (s - a[i]) / (1 << EPS_SHIFT);
        a[i] = (inh >= a[i]) ? 0 : a[i] - inh;
      end
      e.iters++;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 at cycle %0d, expected no done", cyc);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.done_cyc);
        chk("busy_during_done", {31'd0, busy}, 32'd1);
        chk("winner_valid", {31'd0, winner_valid}, e.valid);
        chk("timeout", {31'd0, timeout}, e.tmo);
        chk("winner_idx", {30'd0, winner_idx}, e.idx);
        chk("winner_act", {24'd0, winner_act}, e.act);
        chk("iter_count", {28'd0, iter_count}, e.iters);
      end
    end
  end

  // Called at a negedge with start about to be sampled while IDLE.
  task automatic issue();
    exp_t e;
    e = ref_model();
    e.done_cyc = cyc + N + 2 + 2 * e.iters;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within 100 cycles, expected a done pulse");
    end
  endtask

  // Entry/exit point: 1ns after the negedge of a done cycle (or any idle negedge).
  task automatic run_case(input logic [3:0] m0, input logic [3:0] m1, input logic [3:0] m2,
                          input logic [3:0] m3, input bit inj, input bit b2b);
    int exp_cyc;
    mem[0] = m0; mem[1] = m1; mem[2] = m2; mem[3] = m3;
    if (b2b) start = 1'b1;  // held through the DONE cycle, where it must be ignored
    @(negedge clk);
    issue();
    exp_cyc = sb[$].done_cyc;
    while (cyc < exp_cyc) begin
      start = inj && ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    wait_done();
    #1;
  endtask

  function automatic logic [3:0] rnd_act();
    return ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
  endfunction

  initial begin
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mem_addr", {30'd0, mem_addr}, 32'd0);
    chk("rst_winner_act", {24'd0, winner_act}, 32'd0);
    chk("rst_iter_count", {28'd0, iter_count}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_case(4'd0, 4'd7, 4'd0, 4'd0, 1'b0, 1'b0);   // immediate winner
    run_case(4'd2, 4'd15, 4'd3, 4'd1, 1'b1, 1'b0);  // normal convergence, starts while busy
    run_case(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);   // all zero
    run_case(4'd5, 4'd5, 4'd0, 4'd0, 1'b1, 1'b0);   // tie -> timeout
    run_case(4'd3, 4'd9, 4'd1, 4'd0, 1'b0, 1'b1);   // start in DONE ignored, next cycle taken
    run_case(4'd2, 4'd15, 4'd3, 4'd1, 1'b0, 1'b1);

    // Reset while iterating: outputs clear at once and the pending run never completes.
    mem[0] = 4'd5; mem[1] = 4'd5; mem[2] = 4'd0; mem[3] = 4'd0;
    @(negedge clk);
    issue();
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    sb.delete();
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_mem_addr", {30'd0, mem_addr}, 32'd0);
    chk("midrst_winner_valid", {31'd0, winner_valid}, 32'd0);
    chk("midrst_timeout", {31'd0, timeout}, 32'd0);
    chk("midrst_winner_idx", {30'd0, winner_idx}, 32'd0);
    chk("midrst_winner_act", {24'd0, winner_act}, 32'd0);
    chk("midrst_iter_count", {28'd0, iter_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_reset_idle", {31'd0, busy}, 32'd0);
    run_case(4'd2, 4'd15, 4'd3, 4'd1, 1'b0, 1'b0);

    for (int r = 0; r < 30; r++) begin
      run_case(rnd_act(), rnd_act(), rnd_act(), rnd_act(),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by %0t, expected the run to finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/maxnet_sequencer.md
# maxnet_sequencer

Controller and iteration engine for the Maxnet winner-take-all network. On `start` it fetches the N initial activations from the data memory one address per cycle, then runs Maxnet lateral-inhibition iterations until exactly one activation is non-zero, all are zero, or an iteration limit is reached. It reports the winning neuron index and its final activation. The block sits between the top-level control and the 4-entry activation memory and is the only master of that memory's read address.

## Interface
- `N`, 4: number of neurons and memory entries; the address width is clog2(N).
- `DW`, 4: width of one memory word (unsigned activation).
- `FRAC`, 4: fractional bits appended on load; internal activation width `AW = DW+FRAC`.
- `EPS_SHIFT`, 3: inhibition weight epsilon = 2^-EPS_SHIFT.
- `MAX_ITER`, 15: iteration limit; the `iter_count` width is clog2(MAX_ITER+1).

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request to begin; ignored unless the state is IDLE.
- `mem_addr` out clog2(N): memory read address; the memory read is combinational in the same cycle.
- `mem_data` in DW: memory word at `mem_addr`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when results become valid.
- `winner_valid` out 1: exactly one neuron survived.
- `timeout` out 1: the iteration limit was hit with more than one survivor.
- `winner_idx` out clog2(N): index of the surviving neuron.
- `winner_act` out AW: final activation of the winner.
- `iter_count` out clog2(MAX_ITER+1): number of iterations executed.

## Operation
- **States:** IDLE, LOAD, CHECK, ITER, DONE. The state is registered.
- **IDLE:** `mem_addr` = 0. When `start` = 1, clear `iter_count`, `load_idx` = 0, and go to LOAD.
- **LOAD:** `mem_addr` = `load_idx`. On the edge, `a[load_idx]` <= `{mem_data, FRAC zeros}` and `load_idx` increments. After `load_idx` = N-1 is loaded, go to CHECK. LOAD lasts exactly N cycles.
- **CHECK:** `nz` = number of `a[i]` != 0. The first matching rule applies:
  - `nz` = 1: go to DONE with valid.
  - `nz` = 0: go to DONE with invalid, `timeout` = 0.
  - `iter_count` = MAX_ITER: go to DONE with `timeout` = 1.
  - Otherwise: go to ITER.
- **ITER:** all neurons update in parallel in one edge, then `iter_count`++ and go to CHECK.
  - `S` = sum of all `a[j]`, width AW+clog2(N).
  - `inh_i` = (`S` - `a[i]`) >> `EPS_SHIFT`.
  - `a[i]` <= (`inh_i` >= `a[i]`) ? 0 : `a[i]` - `inh_i`. This saturates at 0 (ReLU) and never wraps.
- **DONE:** `done` = 1 for this one cycle, then go to IDLE.
  - Result outputs are registered when leaving CHECK and are held until the next accepted `start`.
  - `winner_idx` and `winner_act` are 0 when `winner_valid` = 0.
- **`start` handling:** `start` while `busy` is ignored and does not queue. `start` in the DONE cycle is also ignored.

## Timing
- **Reset values:** state IDLE; all `a[i]` = 0.
  - `mem_addr`, `busy`, `done`, `winner_valid`, `timeout`, `winner_idx`, `winner_act` and `iter_count` are all 0.
- **Reset mid-operation** aborts immediately to IDLE with the reset values above. No `done` is produced.
- **Start edge:** the edge that samples `start` is edge 0. `busy` goes high after edge 0.
- **Done timing:** with I iterations, `done` is high in the cycle after edge N+1+2I. That is edge 5 for I=0 and N=4. `busy` falls together with `done`.
- **Per-iteration cost:** each iteration costs exactly 2 cycles (ITER + CHECK). Worst case total is N+2+2·MAX_ITER cycles.
- **Loaded values** are visible in `a` on the edge after their address is driven. There is no memory latency.

## Test plan
- **Immediate winner:** memory {0,7,0,0}, pulse `start` → `done` after edge 5; `winner_valid` = 1, `winner_idx` = 1, `winner_act` = 0x70, `iter_count` = 0.
- **Normal convergence:** memory {2,15,3,1} → after iteration 1, `a` = {0,228,12,0}; after iteration 2, `a` = {0,227,0,0}. `done` after edge 9; `winner_idx` = 1, `winner_act` = 0xE3, `iter_count` = 2.
- **All zero:** memory {0,0,0,0} → `done` after edge 5; `winner_valid` = 0, `timeout` = 0, `iter_count` = 0.
- **Tie / timeout:** memory {5,5,0,0} → both survivors decay 80→70→62…; `done` after edge 35; `timeout` = 1, `winner_valid` = 0, `iter_count` = 15.
- **Start while busy:** pulse `start` during LOAD and during ITER → no restart and the result is unchanged. A `start` in the cycle after `done` is accepted and reloads memory.
- **Reset mid-run:** assert `rst` during ITER → all outputs read 0 in the same cycle and no `done` appears. A subsequent `start` completes a full, correct run.
